// File: rtl/mem_load_align_if.sv
// Request/writeback bundle for the load-align stage.
//   req_*  : instruction entering the stage (valid, op, alu/address, old rt value, we, tag)
//   out_*  : registered writeback view (valid, we, tag, wdata, address-error flag)
// Modports: master drives req_* and observes out_*; slave is the stage itself.
// DATA_W/TAG_W must match the parameters of the mem_load_align instance using it.
interface mem_load_align_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
);
  logic              req_valid;
  logic [3:0]        req_op;
  logic [DATA_W-1:0] req_alu;
  logic [DATA_W-1:0] req_old;
  logic              req_we;
  logic [TAG_W-1:0]  req_tag;

  logic              out_valid;
  logic              out_we;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_wdata;
  logic              out_adel;

  modport master (
    output req_valid, req_op, req_alu, req_old, req_we, req_tag,
    input  out_valid, out_we, out_tag, out_wdata, out_adel
  );

  modport slave (
    input  req_valid, req_op, req_alu, req_old, req_we, req_tag,
    output out_valid, out_we, out_tag, out_wdata, out_adel
  );
endinterface

// File: rtl/mem_load_align.sv
// Memory-stage load aligner: registers one instruction plus the synchronous SRAM read data,
// then selects/extends bytes, halfwords, words (and doublewords at DATA_W=64) and performs
// the lwl/lwr partial-word merges. Read data returned while the stage is held is parked in a
// one-entry buffer so the first-stall-cycle value survives until the stage advances.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : drop held instruction and buffered read data
//   stall_cur     : this stage held
//   stall_nxt     : downstream stage held
//   sram_rdata    : data-SRAM read data for the request being accepted
//   bus (slave)   : req_* inputs, out_* registered writeback outputs
module mem_load_align #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_cur,
  input  logic              stall_nxt,
  input  logic [DATA_W-1:0] sram_rdata,
  mem_load_align_if.slave   bus
);

  localparam bit Is64 = (DATA_W == 64);

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [3:0] {
    OpNone = 4'd0,
    OpLb   = 4'd1,
    OpLbu  = 4'd2,
    OpLh   = 4'd3,
    OpLhu  = 4'd4,
    OpLw   = 4'd5,
    OpLwu  = 4'd6,
    OpLd   = 4'd7,
    OpLwl  = 4'd8,
    OpLwr  = 4'd9
  } op_e;

  typedef struct packed {
    logic             valid;
    logic [3:0]       op;
    data_t            alu;
    data_t            old;
    logic             we;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t stage_d, stage_q;
  data_t  rdata_d, rdata_q;
  data_t  buf_d, buf_q;
  logic   flag_d, flag_q;

  // Next-state: flush/bubble clears, advance loads, held stage parks the first read data only.
  always_comb begin
    stage_d = stage_q;
    rdata_d = rdata_q;
    buf_d   = buf_q;
    flag_d  = flag_q;
    if (flush || (stall_cur && !stall_nxt)) begin
      stage_d = '0;
      rdata_d = '0;
      flag_d  = 1'b0;
    end else if (!stall_cur) begin
      stage_d = '{valid: bus.req_valid, op: bus.req_op, alu: bus.req_alu, old: bus.req_old,
                  we: bus.req_we, tag: bus.req_tag};
      rdata_d = flag_q ? buf_q : sram_rdata;
      flag_d  = 1'b0;
    end else if (!flag_q) begin
      buf_d  = sram_rdata;
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      rdata_q <= '0;
      buf_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      rdata_q <= rdata_d;
      buf_q   <= buf_d;
      flag_q  <= flag_d;
    end
  end

  // Byte offset within the read data; alu[2] only participates at 64 bits.
  logic [2:0]  boff;
  logic [31:0] sel;
  logic [31:0] word;
  logic [1:0]  n;
  logic [4:0]  lsh, rsh;
  logic [31:0] lwl_w, lwr_w;

  assign boff = {Is64 & stage_q.alu[2], stage_q.alu[1:0]};
  assign sel  = 32'(rdata_q >> {boff, 3'b000});
  assign word = (Is64 && stage_q.alu[2]) ? rdata_q[DATA_W-1 -: 32] : rdata_q[31:0];
  assign n    = stage_q.alu[1:0];
  assign lsh  = {2'd3 - n, 3'b000};
  assign rsh  = {n, 3'b000};

  // lwl keeps the low (3-n) bytes of old; lwr keeps the high n bytes of old.
  assign lwl_w = (word << lsh) | (stage_q.old[31:0] & ~(32'hFFFF_FFFF << lsh));
  assign lwr_w = (word >> rsh) | (stage_q.old[31:0] & ~(32'hFFFF_FFFF >> rsh));

  data_t result;
  logic  misalign;
  logic  adel;

  always_comb begin
    result   = stage_q.alu;
    misalign = 1'b0;
    case (stage_q.op)
      OpLb:  result = data_t'($signed(sel[7:0]));
      OpLbu: result = data_t'(sel[7:0]);
      OpLh: begin
        result   = data_t'($signed(sel[15:0]));
        misalign = stage_q.alu[0];
      end
      OpLhu: begin
        result   = data_t'(sel[15:0]);
        misalign = stage_q.alu[0];
      end
      OpLw: begin
        result   = data_t'($signed(sel));
        misalign = |stage_q.alu[1:0];
      end
      OpLwu: begin
        if (Is64) begin
          result   = data_t'(sel);
          misalign = |stage_q.alu[1:0];
        end
      end
      OpLd: begin
        if (Is64) begin
          result   = rdata_q;
          misalign = |stage_q.alu[2:0];
        end
      end
      OpLwl: result = data_t'($signed(lwl_w));
      OpLwr: begin
        result       = stage_q.old;
        result[31:0] = lwr_w;
      end
      default: result = stage_q.alu;
    endcase
  end

  assign adel = stage_q.valid & misalign;

  assign bus.out_valid = stage_q.valid;
  assign bus.out_tag   = stage_q.tag;
  assign bus.out_adel  = adel;
  assign bus.out_we    = stage_q.valid & stage_q.we & ~adel;
  assign bus.out_wdata = adel ? '0 : result;

endmodule

// File: tb/tb_mem_load_align.sv
// Bench for mem_load_align: a 32-bit and a 64-bit instance share control and stimulus (the
// 32-bit one sees the low halves); both are checked every cycle against a reference model.
module tb_mem_load_align;

  logic        clk;
  logic        rst, flush, stall_cur, stall_nxt;
  logic        r_valid, r_we;
  logic [3:0]  r_op;
  logic [63:0] r_alu, r_old, sram;
  logic [4:0]  r_tag;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  bit          m_valid, m_we, m_flag;
  logic [3:0]  m_op;
  logic [63:0] m_alu, m_old, m_rd, m_buf;
  logic [4:0]  m_tag;

  mem_load_align_if #(.DATA_W(32), .TAG_W(5)) if32 ();
  mem_load_align_if #(.DATA_W(64), .TAG_W(5)) if64 ();

  assign if32.req_valid = r_valid;
  assign if32.req_op    = r_op;
  assign if32.req_alu   = r_alu[31:0];
  assign if32.req_old   = r_old[31:0];
  assign if32.req_we    = r_we;
  assign if32.req_tag   = r_tag;
  assign if64.req_valid = r_valid;
  assign if64.req_op    = r_op;
  assign if64.req_alu   = r_alu;
  assign if64.req_old   = r_old;
  assign if64.req_we    = r_we;
  assign if64.req_tag   = r_tag;

  mem_load_align #(.DATA_W(32), .TAG_W(5)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .stall_cur(stall_cur), .stall_nxt(stall_nxt),
    .sram_rdata(sram[31:0]), .bus(if32)
  );

  mem_load_align #(.DATA_W(64), .TAG_W(5)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .stall_cur(stall_cur), .stall_nxt(stall_nxt),
    .sram_rdata(sram), .bus(if64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] sx(input logic [63:0] x, input int b);
    if (x[b-1]) return x | ~((64'd1 << b) - 64'd1);
    return x;
  endfunction

  // Expected writeback from the load rules, using byte arithmetic on the whole read word.
  function automatic void ref_out(input bit is64, input bit v, input logic [3:0] op,
                                  input logic [63:0] alu_i, input logic [63:0] old_i,
                                  input logic [63:0] rd_i, input bit we,
                                  output logic e_we, output logic [63:0] e_wd,
                                  output logic e_adel);
    logic [63:0] msk, alu, old, rd, sel, word, r, r32;
    int off, nb, s;
    bit ad;
    msk  = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    alu  = alu_i & msk;
    old  = old_i & msk;
    rd   = rd_i & msk;
    off  = is64 ? int'(alu[2:0]) : int'(alu[1:0]);
    nb   = int'(alu[1:0]);
    sel  = rd >> (8 * off);
    word = ((is64 && alu[2]) ? (rd >> 32) : rd) & 64'hFFFF_FFFF;
    ad   = 0;
    r    = alu;
    case (op)
      4'd1: r = sx(sel & 64'hFF, 8);
      4'd2: r = sel & 64'hFF;
      4'd3: begin r = sx(sel & 64'hFFFF, 16); ad = (off % 2) != 0; end
      4'd4: begin r = sel & 64'hFFFF; ad = (off % 2) != 0; end
      4'd5: begin r = sx(sel & 64'hFFFF_FFFF, 32); ad = (off % 4) != 0; end
      4'd6: if (is64) begin r = sel & 64'hFFFF_FFFF; ad = (off % 4) != 0; end
      4'd7: if (is64) begin r = rd; ad = off != 0; end
      4'd8: begin
        s   = 8 * (3 - nb);
        r32 = ((word << s) & 64'hFFFF_FFFF) | (old & ((64'd1 << s) - 64'd1));
        r   = sx(r32, 32);
      end
      4'd9: begin
        s   = 8 * nb;
        r32 = (word >> s) | (old & 64'hFFFF_FFFF & ~((64'd1 << (32 - s)) - 64'd1));
        r   = (old & ~64'hFFFF_FFFF) | r32;
      end
      default: r = alu;
    endcase
    ad     = ad && v;
    e_adel = ad;
    e_we   = v && we && !ad;
    e_wd   = ad ? 64'd0 : (r & msk);
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic        ew, ead;
    logic [63:0] ewd;
    ref_out(1'b0, m_valid, m_op, m_alu, m_old, m_rd, m_we, ew, ewd, ead);
    cmp({tag, ".valid32"}, 64'(if32.out_valid), 64'(m_valid));
    cmp({tag, ".tag32"},   64'(if32.out_tag),   64'(m_tag));
    cmp({tag, ".we32"},    64'(if32.out_we),    64'(ew));
    cmp({tag, ".adel32"},  64'(if32.out_adel),  64'(ead));
    cmp({tag, ".wdata32"}, 64'(if32.out_wdata), ewd);
    ref_out(1'b1, m_valid, m_op, m_alu, m_old, m_rd, m_we, ew, ewd, ead);
    cmp({tag, ".valid64"}, 64'(if64.out_valid), 64'(m_valid));
    cmp({tag, ".tag64"},   64'(if64.out_tag),   64'(m_tag));
    cmp({tag, ".we64"},    64'(if64.out_we),    64'(ew));
    cmp({tag, ".adel64"},  64'(if64.out_adel),  64'(ead));
    cmp({tag, ".wdata64"}, if64.out_wdata,      ewd);
  endtask

  // One clock: update the reference with the inputs sampled at the edge, then check.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) begin
      {m_valid, m_we, m_flag} = '0;
      {m_op, m_alu, m_old, m_rd, m_buf, m_tag} = '0;
    end else if (flush || (stall_cur && !stall_nxt)) begin
      {m_valid, m_we, m_flag} = '0;
      {m_op, m_alu, m_old, m_rd, m_tag} = '0;
    end else if (!stall_cur) begin
      m_valid = r_valid; m_op = r_op; m_alu = r_alu; m_old = r_old; m_we = r_we; m_tag = r_tag;
      m_rd    = m_flag ? m_buf : sram;
      m_flag  = 0;
    end else if (!m_flag) begin
      m_buf  = sram;
      m_flag = 1;
    end
    #1;
    check_all(tag);
  endtask

  task automatic set_req(input bit v, input logic [3:0] op, input logic [63:0] alu,
                         input logic [63:0] old, input bit we, input logic [4:0] tag);
    r_valid = v; r_op = op; r_alu = alu; r_old = old; r_we = we; r_tag = tag;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall_cur = 1'b0; stall_nxt = 1'b0; sram = 64'd0;
    set_req(1, 4'd5, 64'h1234, 64'h55, 1, 5'd9);
    tick("reset");
    tick("reset");
    cmp("rst_valid", 64'(if32.out_valid), 64'd0);
    cmp("rst_wdata", if64.out_wdata, 64'd0);
    cmp("rst_tag", 64'(if64.out_tag), 64'd0);
    rst = 1'b0;

    // Signed byte from offset 3
    set_req(1, 4'd1, 64'h1000_0003, 64'd0, 1, 5'd3);
    sram = 64'h0000_0000_80AA_5511;
    tick("lb");
    cmp("lb_wdata32", 64'(if32.out_wdata), 64'h0000_0000_FFFF_FF80);
    cmp("lb_we32", 64'(if32.out_we), 64'd1);
    cmp("lb_wdata64", if64.out_wdata, 64'hFFFF_FFFF_FFFF_FF80);

    // Partial-word merges at n=1
    set_req(1, 4'd8, 64'h1, 64'h0000_0000_1234_5678, 1, 5'd4);
    sram = 64'h0000_0000_AABB_CCDD;
    tick("lwl");
    cmp("lwl_wdata32", 64'(if32.out_wdata), 64'h0000_0000_CCDD_5678);
    cmp("lwl_wdata64", if64.out_wdata, 64'hFFFF_FFFF_CCDD_5678);
    set_req(1, 4'd9, 64'h1, 64'h0000_0000_1234_5678, 1, 5'd4);
    tick("lwr");
    cmp("lwr_wdata32", 64'(if32.out_wdata), 64'h0000_0000_12AA_BBCC);
    cmp("lwr_wdata64", if64.out_wdata, 64'h0000_0000_12AA_BBCC);

    // Misaligned halfword
    set_req(1, 4'd3, 64'h1, 64'd0, 1, 5'd6);
    tick("lh_adel");
    cmp("lh_adel32", 64'(if32.out_adel), 64'd1);
    cmp("lh_we32", 64'(if32.out_we), 64'd0);
    cmp("lh_wdata64", if64.out_wdata, 64'd0);

    // Doubleword and upper-word loads
    set_req(1, 4'd7, 64'h8, 64'd0, 1, 5'd7);
    sram = 64'h0123_4567_89AB_CDEF;
    tick("ld");
    cmp("ld_wdata64", if64.out_wdata, 64'h0123_4567_89AB_CDEF);
    set_req(1, 4'd5, 64'h4, 64'd0, 1, 5'd7);
    tick("lw_hi");
    cmp("lw_hi_wdata64", if64.out_wdata, 64'h0000_0000_0123_4567);

    // Held stage keeps only the first-cycle read data
    set_req(1, 4'd5, 64'h0, 64'd0, 1, 5'd8);
    sram = 64'd0;
    tick("stall_pre");
    set_req(1, 4'd5, 64'h0, 64'd0, 1, 5'd10);
    stall_cur = 1'b1; stall_nxt = 1'b1;
    sram = 64'h1111_1111_1111_1111; tick("stall1");
    sram = 64'h2222_2222_2222_2222; tick("stall2");
    sram = 64'h3333_3333_3333_3333; tick("stall3");
    stall_cur = 1'b0; stall_nxt = 1'b0;
    sram = 64'h4444_4444_4444_4444;
    tick("stall_rel");
    cmp("stall_buf32", 64'(if32.out_wdata), 64'h0000_0000_1111_1111);
    cmp("stall_buf64", if64.out_wdata, 64'h0000_0000_1111_1111);

    // Bubble when only this stage is held
    stall_cur = 1'b1;
    tick("bubble");
    cmp("bubble_valid", 64'(if64.out_valid), 64'd0);

    // Flush during a buffered stall
    stall_nxt = 1'b1;
    sram = 64'h6666_6666_6666_6666; tick("fstall1");
    sram = 64'h7777_7777_7777_7777; tick("fstall2");
    flush = 1'b1;
    tick("flush");
    cmp("flush_valid", 64'(if32.out_valid), 64'd0);
    flush = 1'b0; stall_cur = 1'b0; stall_nxt = 1'b0;
    sram = 64'h5555_5555_5555_5555;
    tick("flush_live");
    cmp("flush_live32", 64'(if32.out_wdata), 64'h0000_0000_5555_5555);

    // Reset in the middle of a buffered stall
    stall_cur = 1'b1; stall_nxt = 1'b1;
    sram = 64'h9999_9999_9999_9999; tick("rstall1");
    tick("rstall2");
    rst = 1'b1;
    tick("rstall_rst");
    rst = 1'b0; stall_cur = 1'b0; stall_nxt = 1'b0;
    sram = 64'h1357_9BDF_2468_ACE0;
    tick("rst_live");
    cmp("rst_live64", if64.out_wdata, 64'h0000_0000_2468_ACE0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [63:0] a;
      rst       = ($urandom_range(0, 59) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      stall_cur = ($urandom_range(0, 3) == 0);
      stall_nxt = ($urandom_range(0, 1) == 0);
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'd0;
      set_req($urandom_range(0, 4) != 0, 4'($urandom_range(0, 11)), a,
              {$urandom, $urandom}, $urandom_range(0, 1) == 1, 5'($urandom));
      sram = {$urandom, $urandom};
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_load_align.md
MEM_LOAD_ALIGN -- requirements
Module: mem_load_align

Interface
REQ-001 SHALL have parameter DATA_W, default 32, load/writeback data width; legal values 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 5, destination register index width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard held instruction and buffered read data.
REQ-006 SHALL have port stall_cur  input  1  this stage held (Stop).
REQ-007 SHALL have port stall_nxt  input  1  downstream stage held.
REQ-008 SHALL have port req_valid  input  1  upstream instruction present.
REQ-009 SHALL have port req_op  input  4  0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 lwu, 7 ld, 8 lwl, 9 lwr; other codes = none.
REQ-010 SHALL have port req_alu  input  DATA_W  ALU result / effective address.
REQ-011 SHALL have port req_old  input  DATA_W  current rt value, merged by lwl/lwr.
REQ-012 SHALL have port req_we  input  1  register write request.
REQ-013 SHALL have port req_tag  input  TAG_W  destination register.
REQ-014 SHALL have port sram_rdata  input  DATA_W  synchronous data-SRAM read data, valid the edge the request enters this stage.
REQ-015 SHALL have port out_valid  output  1  registered instruction valid.
REQ-016 SHALL have port out_we  output  1  writeback enable.
REQ-017 SHALL have port out_tag  output  TAG_W  writeback register.
REQ-018 SHALL have port out_wdata  output  DATA_W  writeback data.
REQ-019 SHALL have port out_adel  output  1  address-error-on-load flag.

Function
REQ-020 SHALL hold one stage register {valid, op, alu, old, we, tag}, a read-data register rdata_r, a DATA_W buffer and a 1-bit buffer flag.
REQ-021 SHALL update state with priority: rst; flush; stall_cur=1 & stall_nxt=0; stall_cur=0; stall_cur=1 & stall_nxt=1.
REQ-022 SHALL on flush, or stall_cur=1 & stall_nxt=0, clear stage register, rdata_r and flag (bubble; out_valid=0 next cycle).
REQ-023 SHALL on stall_cur=0 load stage register from req_*, load rdata_r from buffer if flag=1 else from sram_rdata, clear flag.
REQ-024 SHALL on stall_cur=1 & stall_nxt=1 with flag=0 capture sram_rdata into buffer, set flag; with flag=1 hold everything (first-stall-cycle data retained, later sram_rdata ignored).
REQ-025 SHALL produce outputs combinationally from registered state only; latency request-to-output exactly one cycle after acceptance.
REQ-026 SHALL index bytes little-endian by alu[1:0] when DATA_W=32 (alu[2] ignored) and alu[2:0] when DATA_W=64.
REQ-027 SHALL compute lb/lh/lw sign-extended, lbu/lhu/lwu zero-extended, to DATA_W.
REQ-028 SHALL treat lwu and ld as op none when DATA_W=32.
REQ-029 SHALL for lwl with n=alu[1:0] within the addressed word: result word = (word << 8*(3-n)) | (old[31:0] & low (3-n) byte mask); sign-extend to DATA_W.
REQ-030 SHALL for lwr with n=alu[1:0]: result word = (word >> 8*n) | (old[31:0] & high n byte mask); upper DATA_W-32 bits from old.
REQ-031 SHALL assert out_adel for lh/lhu with alu[0]=1, lw/lwu with alu[1:0]!=0, ld with alu[2:0]!=0; then out_we=0, out_wdata=0.
REQ-032 SHALL output out_wdata = alu for op none, else the load result; out_we = valid & we & !out_adel.
REQ-033 SHALL never assert out_adel for lwl/lwr, lb/lbu, or when valid=0.

Reset
REQ-034 SHALL on rst clear stage register, rdata_r, buffer and flag; out_valid, out_we, out_adel = 0, out_tag = 0, out_wdata = 0 the cycle after rst is sampled.
REQ-035 SHALL let rst asserted mid-stall abandon buffered data; first post-reset accept uses sram_rdata.

Verification
REQ-036 SHALL test DATA_W=32: lb, alu=0x...03, sram_rdata=0x80AA5511 -> out_wdata=0xFFFFFF80, out_we=1.
REQ-037 SHALL test stall: accept lw, stall_cur=stall_nxt=1 for 3 cycles with sram_rdata 0x11111111 then 0x22222222, 0x33333333, release -> next load uses 0x11111111.
REQ-038 SHALL test lwl n=1, word 0xAABBCCDD, old 0x12345678 -> 0xCCDD5678; lwr n=1 -> 0x12AABBCC.
REQ-039 SHALL test lh alu=0x...01 -> out_adel=1, out_we=0, out_wdata=0.
REQ-040 SHALL test DATA_W=64: ld alu=0x...08, rdata 0x0123456789ABCDEF -> same value; lw alu=0x...04 -> 0x0000000001234567.
REQ-041 SHALL test flush during buffered stall -> out_valid=0 next cycle, flag cleared, next accept uses live sram_rdata.
